fp_normalize: RTL and testbench

Normalization stage of the FP32 adder. It sits between the mantissa add/subtract stage and the rounding stage. It takes the raw signed-magnitude sum and its exponent, then normalizes the hidden one to bit 24. Normalization uses a 1-bit right shift on carry-out or an iterative 1-bit-per-cycle left shift on cancellation. It emits the sign, the adjusted exponent and the 24-bit M_NORM field (23 fraction bits plus 1 round bit, round bit at [0]), and forwards round_mode unchanged to the rounder.

---
 rtl/fp_normalize.sv | 188 ++++++++++++++++++
 tb/tb_fp_normalize.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// fp_normalize: normalization stage of the FP32 adder, placed between the
// mantissa add/subtract stage and the rounder.
//
// Takes the raw signed-magnitude sum and its exponent. A carry-out is fixed
// with a single right shift. A cancellation is fixed with an iterative left
// shift of one bit per cycle until the hidden one reaches bit FRAC_W+1, or
// until the exponent reaches the subnormal floor.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid        upstream sum valid
//   in_ready        high iff the FSM is idle
//   s_in            sign of the sum
//   e_in            biased exponent before normalization
//   m_sum           [FRAC_W+2] carry-out, [FRAC_W+1] hidden-one position,
//                   [FRAC_W:1] fraction, [0] round bit
//   round_mode_in   rounding mode, forwarded unchanged
//   out_valid       result valid (registered)
//   out_ready       rounder accepts the result
//   s               sign, passed through
//   e_norm          normalized biased exponent
//   m_norm          normalized fraction plus round bit (hidden one dropped)
//   round_mode      captured rounding mode
//   ovf             exponent overflow, the result is infinity
//   zero            exact zero result
module fp_normalize #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s_in,
  input  logic [EXP_W-1:0]  e_in,
  input  logic [FRAC_W+2:0] m_sum,
  input  logic [1:0]        round_mode_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s,
  output logic [EXP_W-1:0]  e_norm,
  output logic [FRAC_W:0]   m_norm,
  output logic [1:0]        round_mode,
  output logic              ovf,
  output logic              zero
);

  // Working mantissa keeps the hidden one at its top bit.
  localparam int MW = FRAC_W + 2;

  localparam logic [EXP_W-1:0] E_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] E_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] E_ONES = {EXP_W{1'b1}};
  localparam logic [MW-1:0]    M_ZERO = {MW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [EXP_W-1:0]  e_r, e_s;
  logic [MW-1:0]     m_r, m_s;
  logic              s_r, s_s;
  logic [1:0]        rm_r, rm_s;
  logic              ovf_r, ovf_s;
  logic              zero_r, zero_s;
  logic              out_valid_r;

  logic [EXP_W-1:0]  e_inc_s;
  logic [EXP_W-1:0]  e_dec_s;
  logic [MW-1:0]     m_shl_s;

  assign e_inc_s = e_in + E_ONE;
  assign e_dec_s = e_r - E_ONE;
  assign m_shl_s = {m_r[MW-2:0], 1'b0};

  // Next-state and next working-register values.
  always_comb begin
    state_s = state_r;
    e_s     = e_r;
    m_s     = m_r;
    s_s     = s_r;
    rm_s    = rm_r;
    ovf_s   = ovf_r;
    zero_s  = zero_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          s_s    = s_in;
          rm_s   = round_mode_in;
          ovf_s  = 1'b0;
          zero_s = 1'b0;
          if (m_sum == {(MW+1){1'b0}}) begin
            zero_s  = 1'b1;
            e_s     = E_ZERO;
            m_s     = M_ZERO;
            state_s = HOLD;
          end else if (m_sum[MW]) begin
            // Carry-out: one right shift; the old round bit falls off.
            if (e_inc_s == E_ONES) begin
              ovf_s = 1'b1;
              e_s   = E_ONES;
              m_s   = M_ZERO;
            end else begin
              e_s   = e_inc_s;
              m_s   = m_sum[MW:1];
            end
            state_s = HOLD;
          end else if (m_sum[MW-1]) begin
            e_s     = e_in;
            m_s     = m_sum[MW-1:0];
            state_s = HOLD;
          end else if (e_in <= E_ONE) begin
            // Already in the subnormal range: no room to shift left.
            e_s     = E_ZERO;
            m_s     = m_sum[MW-1:0];
            state_s = HOLD;
          end else begin
            e_s     = e_in;
            m_s     = m_sum[MW-1:0];
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        m_s = m_shl_s;
        if (m_shl_s[MW-1]) begin
          e_s     = e_dec_s;
          state_s = HOLD;
        end else if (e_dec_s == E_ONE) begin
          // Exponent hit the subnormal floor: stop and encode as E=0.
          e_s     = E_ZERO;
          state_s = HOLD;
        end else begin
          e_s     = e_dec_s;
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and working registers; out_valid tracks entry into HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      e_r         <= E_ZERO;
      m_r         <= M_ZERO;
      s_r         <= 1'b0;
      rm_r        <= 2'b00;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      e_r         <= e_s;
      m_r         <= m_s;
      s_r         <= s_s;
      rm_r        <= rm_s;
      ovf_r       <= ovf_s;
      zero_r      <= zero_s;
      out_valid_r <= (state_s == HOLD);
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = out_valid_r;
  assign s          = s_r;
  assign e_norm     = e_r;
  assign m_norm     = m_r[FRAC_W:0];
  assign round_mode = rm_r;
  assign ovf        = ovf_r;
  assign zero       = zero_r;

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed vectors, a behavioural
// model computing expected results from the leading-one position, and a
// compare process that checks every output on every valid cycle.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        s_in = 1'b0;
  logic [7:0]  e_in = 8'h00;
  logic [25:0] m_sum = 26'h0;
  logic [1:0]  round_mode_in = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        s;
  logic [7:0]  e_norm;
  logic [23:0] m_norm;
  logic [1:0]  round_mode;
  logic        ovf;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic        ovf;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t       cur_exp;
  logic       cur_s;
  logic [1:0] cur_rm;

  fp_normalize #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .e_in(e_in), .m_sum(m_sum), .round_mode_in(round_mode_in),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .e_norm(e_norm),
    .m_norm(m_norm), .round_mode(round_mode), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Expected result from the normalization rules, using plain arithmetic.
  function automatic exp_t model(input logic [7:0] ei, input logic [25:0] ms);
    exp_t   r;
    int     pos;
    int     need;
    int     k;
    longint v;
    longint sh;
    r.ovf = 1'b0; r.zero = 1'b0; r.lat = 1;
    v = longint'(ms);
    if (v == 0) begin
      r.zero = 1'b1; r.e = 8'h00; r.m = 24'h0;
    end else if (v >= (64'd1 << 25)) begin
      if (int'(ei) + 1 == 255) begin
        r.ovf = 1'b1; r.e = 8'hFF; r.m = 24'h0;
      end else begin
        r.e = 8'(int'(ei) + 1);
        r.m = 24'((v / 2) % (64'd1 << 24));
      end
    end else if (v >= (64'd1 << 24)) begin
      r.e = ei; r.m = 24'(v % (64'd1 << 24));
    end else if (int'(ei) <= 1) begin
      r.e = 8'h00; r.m = 24'(v % (64'd1 << 24));
    end else begin
      pos = 0;
      for (int i = 0; i < 26; i++) if (ms[i]) pos = i;
      need = 24 - pos;
      if (need <= int'(ei) - 1) begin
        k = need; r.e = 8'(int'(ei) - need);
      end else begin
        k = int'(ei) - 1; r.e = 8'h00;
      end
      sh = v << k;
      r.m = 24'(sh % (64'd1 << 24));
      r.lat = 1 + k;
    end
    return r;
  endfunction

  // Output checker: every cycle the result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("s", 32'(s), 32'(cur_s));
      chk("e_norm", 32'(e_norm), 32'(cur_exp.e));
      chk("m_norm", 32'(m_norm), 32'(cur_exp.m));
      chk("round_mode", 32'(round_mode), 32'(cur_rm));
      chk("ovf", 32'(ovf), 32'(cur_exp.ovf));
      chk("zero", 32'(zero), 32'(cur_exp.zero));
    end
  end

  task automatic run_vec(input logic si, input logic [7:0] ei, input logic [25:0] ms,
                         input logic [1:0] rm, input int hold,
                         input bit use_lit, input logic [7:0] le, input logic [23:0] lm,
                         input logic lovf, input logic lzero, input int llat);
    int cyc;
    bit got;
    cur_exp = model(ei, ms);
    cur_s   = si;
    cur_rm  = rm;
    if (use_lit) begin
      chk("model_e", 32'(cur_exp.e), 32'(le));
      chk("model_m", 32'(cur_exp.m), 32'(lm));
      chk("model_ovf", 32'(cur_exp.ovf), 32'(lovf));
      chk("model_zero", 32'(cur_exp.zero), 32'(lzero));
      chk("model_lat", 32'(cur_exp.lat), 32'(llat));
    end
    @(posedge clk); #1;
    in_valid = 1'b1; s_in = si; e_in = ei; m_sum = ms; round_mode_in = rm;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) got = 1'b1;
      else chk("in_ready_busy", 32'(in_ready), 32'd0);
    end
    chk("out_valid_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(cur_exp.lat));
    // Backpressure with a competing upstream request that must not be taken.
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; s_in = ~si; e_in = 8'h33; m_sum = 26'h1234567; round_mode_in = ~rm;
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    cur_exp = model(8'h00, 26'h0);
    cur_s = 1'b0; cur_rm = 2'b00;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({s, e_norm, m_norm, round_mode, ovf, zero}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_vec(1'b1, 8'h80, 26'h1000002, 2'b00, 0, 1'b1, 8'h80, 24'h000002, 1'b0, 1'b0, 1);
    run_vec(1'b0, 8'h7F, 26'h3000001, 2'b01, 0, 1'b1, 8'h80, 24'h800000, 1'b0, 1'b0, 1);
    run_vec(1'b0, 8'h90, 26'h0000100, 2'b10, 5, 1'b1, 8'h80, 24'h000000, 1'b0, 1'b0, 17);
    run_vec(1'b1, 8'hFE, 26'h2000000, 2'b11, 0, 1'b1, 8'hFF, 24'h000000, 1'b1, 1'b0, 1);
    run_vec(1'b0, 8'h45, 26'h0000000, 2'b00, 0, 1'b1, 8'h00, 24'h000000, 1'b0, 1'b1, 1);
    run_vec(1'b0, 8'h03, 26'h0010000, 2'b01, 0, 1'b1, 8'h00, 24'h040000, 1'b0, 1'b0, 3);
    run_vec(1'b1, 8'h05, 26'h0000001, 2'b10, 2, 1'b1, 8'h00, 24'h000010, 1'b0, 1'b0, 5);
    run_vec(1'b0, 8'h01, 26'h00000F0, 2'b11, 0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 0);
    run_vec(1'b1, 8'h20, 26'h00ABCDE, 2'b00, 1, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 0);
    run_vec(1'b0, 8'h7F, 26'h1FFFFFF, 2'b10, 0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 0);
    run_vec(1'b1, 8'h02, 26'h0800000, 2'b01, 0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 0);

    // Reset in the middle of a long cancellation shift.
    @(posedge clk); #1;
    in_valid = 1'b1; s_in = 1'b1; e_in = 8'h90; m_sum = 26'h0000100; round_mode_in = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("shift_busy", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_outs", 32'({s, e_norm, m_norm, round_mode, ovf, zero}), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
    end

    run_vec(1'b0, 8'h7F, 26'h3000001, 2'b10, 0, 1'b1, 8'h80, 24'h800000, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
